// File: rtl/riot_pkg.sv
// riot_pkg: register offsets and ECR field positions for riot_port_bank
package riot_pkg;
  localparam int ECR_EN_LSB = 0;
  localparam int ECR_POL_LSB = 4;
  function automatic int or_addr(int p);
    return 2 * p;
  endfunction
  function automatic int ddr_addr(int p);
    return 2 * p + 1;
  endfunction
  function automatic int ecr_addr(int n);
    return 2 * n;
  endfunction
  function automatic int ifr_addr(int n);
    return 2 * n + 1;
  endfunction
endpackage

// File: rtl/riot_edge_detect.sv
// riot_edge_detect: MSB edge history flop and sticky flag where set wins over clear
module riot_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic msb,
  input  logic pol,
  input  logic clr,
  output logic flag
);
  logic hist;
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 1'b0;
      flag <= 1'b0;
    end else begin
      hist <= msb;
      flag <= ((msb != hist) && (msb == pol)) || (flag && !clr);
    end
  end
endmodule

// File: rtl/riot_port_bank.sv
// riot_port_bank: NUM_PORTS OR/DDR pad ports with synchronisers; edge IRQs when RIOT_EDGE_IRQ_EN is defined
module riot_port_bank
  import riot_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W = 8,
  localparam int ADDR_W = $clog2(2 * NUM_PORTS + 2)
) (
  input  logic                        phi2,
  input  logic                        rst,
  input  logic                        cs,
  input  logic                        we_n,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [PORT_W-1:0]           di,
  output logic [PORT_W-1:0]           rdata,
  output logic                        oe,
  input  logic [NUM_PORTS*PORT_W-1:0] pin_i,
  output logic [NUM_PORTS*PORT_W-1:0] pin_o,
  output logic [NUM_PORTS*PORT_W-1:0] pin_oe,
  output logic                        irq_n
);
  logic [NUM_PORTS-1:0][PORT_W-1:0] or_q, ddr_q, s1, s2;
  logic [PORT_W-1:0] rd_val;
  logic wr, rd;
  assign wr = cs && !we_n;
  assign rd = cs && we_n;
  assign pin_o = or_q;
  assign pin_oe = ddr_q;
`ifdef RIOT_EDGE_IRQ_EN
  localparam logic [PORT_W-1:0] ECR_MASK =
    PORT_W'(((1 << NUM_PORTS) - 1) << ECR_POL_LSB | ((1 << NUM_PORTS) - 1) << ECR_EN_LSB);
  logic [PORT_W-1:0] ecr;
  logic [NUM_PORTS-1:0] flags;
  logic clr;
  assign clr = rd && (addr == ADDR_W'(ifr_addr(NUM_PORTS)));
  assign irq_n = ~|(flags & ecr[ECR_EN_LSB +: NUM_PORTS]);
  always_ff @(posedge phi2) begin
    if (rst) ecr <= '0;
    else if (wr && addr == ADDR_W'(ecr_addr(NUM_PORTS))) ecr <= di & ECR_MASK;
  end
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_edge
    riot_edge_detect u_edge (
      .clk (phi2),
      .rst (rst),
      .msb (s2[g][PORT_W-1]),
      .pol (ecr[ECR_POL_LSB+g]),
      .clr (clr),
      .flag(flags[g])
    );
  end
`else
  assign irq_n = 1'b1;
`endif
  always_comb begin
    rd_val = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (addr == ADDR_W'(or_addr(p))) rd_val = (or_q[p] & ddr_q[p]) | (s2[p] & ~ddr_q[p]);
      if (addr == ADDR_W'(ddr_addr(p))) rd_val = ddr_q[p];
    end
`ifdef RIOT_EDGE_IRQ_EN
    if (addr == ADDR_W'(ecr_addr(NUM_PORTS))) rd_val = ecr;
    if (addr == ADDR_W'(ifr_addr(NUM_PORTS))) rd_val = PORT_W'(flags);
`endif
  end
  always_ff @(posedge phi2) begin
    if (rst) begin
      or_q <= '0;
      ddr_q <= '0;
      s1 <= '0;
      s2 <= '0;
      rdata <= '0;
      oe <= 1'b0;
    end else begin
      s1 <= pin_i;
      s2 <= s1;
      oe <= rd;
      if (rd) rdata <= rd_val;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr && addr == ADDR_W'(or_addr(p))) or_q[p] <= di;
        if (wr && addr == ADDR_W'(ddr_addr(p))) ddr_q[p] <= di;
      end
    end
  end
endmodule

// File: tb/tb_riot_port_bank.sv
// tb_riot_port_bank: scoreboard bench for riot_port_bank (edge-IRQ checks when RIOT_EDGE_IRQ_EN is defined)
module tb_riot_port_bank;
  logic phi2, rst, cs, we_n, oe, irq_n;
  logic [2:0] addr;
  logic [7:0] di, rdata, e;
  logic [15:0] pin_i, pin_o, pin_oe;
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  riot_port_bank dut (
    .phi2(phi2), .rst(rst), .cs(cs), .we_n(we_n), .addr(addr), .di(di),
    .rdata(rdata), .oe(oe), .pin_i(pin_i), .pin_o(pin_o), .pin_oe(pin_oe), .irq_n(irq_n)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  always @(negedge phi2) begin
    if (oe === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_oe: oe high with no read pending, rdata=%h", rdata);
      end else begin
        e = exp_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", rdata, e);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge phi2);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1; we_n = 0; addr = a; di = d;
    cyc();
    cs = 0; we_n = 1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] x);
    cs = 1; we_n = 1; addr = a;
    exp_q.push_back(x);
    cyc();
    cs = 0;
  endtask

  initial begin
    rst = 1; cs = 0; we_n = 1; addr = 0; di = 0; pin_i = 16'h0000;
    cyc(2);
    rst = 0;
    chk("rst_irq_n", irq_n, 1);
    chk("rst_pin_oe", pin_oe, 16'h0000);
    chk("rst_pin_o", pin_o, 16'h0000);
    chk("rst_oe", oe, 0);
    for (int i = 0; i < 4; i++) rd(i[2:0], 8'h00);
    cyc();
    chk("oe_drop", oe, 0);
    wr(3'd1, 8'hF0);
    wr(3'd0, 8'hA5);
    pin_i[7:0] = 8'h3C;
    cyc(3);
    rd(3'd0, 8'hAC);
    chk("pin_o0", pin_o[7:0], 8'hA5);
    chk("pin_oe0", pin_oe[7:0], 8'hF0);
    rd(3'd1, 8'hF0);
    rd(3'd6, 8'h00);
    wr(3'd7, 8'hFF);
    rd(3'd7, 8'h00);
`ifdef RIOT_EDGE_IRQ_EN
    wr(3'd4, 8'hFF);
    rd(3'd4, 8'h33);
    wr(3'd4, 8'h01);
    rd(3'd4, 8'h01);
    pin_i[7] = 1;
    cyc(3);
    chk("rise_ignored_irq", irq_n, 1);
    rd(3'd5, 8'h00);
    pin_i[7] = 0;
    cyc(2);
    chk("fall_edge2_irq", irq_n, 1);
    cyc();
    chk("fall_edge3_irq", irq_n, 0);
    rd(3'd5, 8'h01);
    chk("ifr_clear_irq", irq_n, 1);
    rd(3'd5, 8'h00);
    wr(3'd4, 8'h22);
    pin_i[15] = 1;
    cyc(2);
    rd(3'd5, 8'h00);
    chk("setwins_irq", irq_n, 0);
    rd(3'd5, 8'h02);
    chk("setwins_clear_irq", irq_n, 1);
`endif
    wr(3'd3, 8'hFF);
    wr(3'd2, 8'h55);
    chk("pin_o1", pin_o[15:8], 8'h55);
    chk("pin_oe1", pin_oe[15:8], 8'hFF);
`ifdef RIOT_EDGE_IRQ_EN
    pin_i[15] = 0;
    cyc(4);
    pin_i[15] = 1;
    cyc(3);
    chk("pre_rst_irq", irq_n, 0);
`endif
    rst = 1; cs = 1; we_n = 0; addr = 3'd2; di = 8'h77;
    cyc();
    rst = 0; cs = 0; we_n = 1;
    chk("mid_rst_irq", irq_n, 1);
    chk("mid_rst_pin_o", pin_o, 16'h0000);
    chk("mid_rst_pin_oe", pin_oe, 16'h0000);
    rd(3'd3, 8'h00);
    rd(3'd4, 8'h00);
    rd(3'd5, 8'h00);
`ifndef RIOT_EDGE_IRQ_EN
    pin_i[7] = 1;
    cyc(4);
    chk("noirq_rise", irq_n, 1);
    pin_i[7] = 0;
    cyc(4);
    chk("noirq_fall", irq_n, 1);
    wr(3'd4, 8'hFF);
    rd(3'd4, 8'h00);
    rd(3'd5, 8'h00);
    chk("noirq_ecr", irq_n, 1);
`endif
    cyc(2);
    chk("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
